// File: rtl/fp_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : specialcases
// Purpose  : FP word, special-case classification and result-buffer types.
// Revision : 1.0 - initial release
// ============================================================================
package specialcases;

    typedef logic [31:0] fp;

    typedef enum logic [2:0] {
        normalizedNumber  = 3'd0,
        nan               = 3'd1,
        positive_infinity = 3'd2,
        negative_infinity = 3'd3,
        zero              = 3'd4,
        overflow          = 3'd5,
        underflow         = 3'd6
    } SpecialCases;

    typedef struct packed {
        fp           result;
        SpecialCases form;
    } buf_entry_t;

    localparam fp FP_QNAN     = 32'h7FC0_0000;
    localparam fp FP_POS_INF  = 32'h7F80_0000;
    localparam fp FP_NEG_INF  = 32'hFF80_0000;
    localparam fp FP_POS_ZERO = 32'h0000_0000;

    // Bit positions follow the multiplier flag vector ordering.
    localparam int unsigned FLAG_W         = 6;
    localparam int unsigned FLAG_NAN       = 5;
    localparam int unsigned FLAG_POS_INF   = 4;
    localparam int unsigned FLAG_NEG_INF   = 3;
    localparam int unsigned FLAG_ZERO      = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    function automatic logic [FLAG_W-1:0] form_flag_mask(input SpecialCases form);
        logic [FLAG_W-1:0] mask;
        mask = '0;
        case (form)
            nan:               mask[FLAG_NAN]       = 1'b1;
            positive_infinity: mask[FLAG_POS_INF]   = 1'b1;
            negative_infinity: mask[FLAG_NEG_INF]   = 1'b1;
            zero:              mask[FLAG_ZERO]      = 1'b1;
            overflow:          mask[FLAG_OVERFLOW]  = 1'b1;
            underflow:         mask[FLAG_UNDERFLOW] = 1'b1;
            default:           mask                 = '0;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_result_buffer_canonicalize.sv
`default_nettype none
// ============================================================================
// Module   : fp_canonicalize
// Purpose  : Maps every non-normal classification to a fixed IEEE-754 pattern.
// Revision : 1.0 - initial release
// ============================================================================
module fp_canonicalize
    import specialcases::*;
(
    input  fp           result_i,
    input  SpecialCases form_i,
    output fp           result_o
);

    always_comb begin
        result_o = result_i;
        case (form_i)
            nan:                         result_o = FP_QNAN;
            positive_infinity, overflow: result_o = FP_POS_INF;
            negative_infinity:           result_o = FP_NEG_INF;
            zero, underflow:             result_o = FP_POS_ZERO;
            default:                     result_o = result_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_buffer
// Purpose  : Elastic FIFO after the FP multiplier with sticky exception status.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_buffer
    import specialcases::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  fp                          in_result,
    input  SpecialCases                in_form,
    output logic                       out_valid,
    input  logic                       out_ready,
    output fp                          out_result,
    output SpecialCases                out_form,
    output logic [$clog2(DEPTH):0]     count,
    output logic [FLAG_W-1:0]          sticky_flags,
    input  logic                       flag_clear,
    output logic [CNT_W-1:0]           exc_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    buf_entry_t          mem_q [DEPTH];
    buf_entry_t          last_pop_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [CNT_W-1:0]    exc_q, exc_d;

    logic                w_push, w_pop, w_exc;
    fp                   w_canon;
    buf_entry_t          w_head;

    fp_canonicalize u_canon (
        .result_i (in_result),
        .form_i   (in_form),
        .result_o (w_canon)
    );

    assign in_ready  = (count_q != c_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_exc     = (in_form != normalizedNumber);

    // When empty the head shows the most recently popped entry, not stale storage.
    assign w_head     = out_valid ? mem_q[rd_ptr_q] : last_pop_q;
    assign out_result = w_head.result;
    assign out_form   = w_head.form;
    assign count      = count_q;
    assign sticky_flags = flags_q;
    assign exc_count    = exc_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A same-cycle push overrides the clear for its own flag and counts from zero.
    always_comb begin
        flags_d = flag_clear ? '0 : flags_q;
        exc_d   = flag_clear ? '0 : exc_q;
        if (w_push) begin
            flags_d = flags_d | form_flag_mask(in_form);
            if (w_exc && (exc_d != c_CNT_MAX)) begin
                exc_d = exc_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flags_q    <= '0;
            exc_q      <= '0;
            last_pop_q <= '{result: FP_POS_ZERO, form: normalizedNumber};
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
            exc_q   <= exc_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                last_pop_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= '{result: w_canon, form: in_form};
        end
    end

endmodule
`default_nettype wire
